curve_point_check: RTL
======================

CURVE_POINT_CHECK -- requirements
Module: curve_point_check

Interface
REQ-001 SHALL have parameter W, default 8, operand and field width in bits.
REQ-002 SHALL have Clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have Reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have Start  input  1  request to check one point; sampled only in IDLE.
REQ-005 SHALL have p  input  W  field prime; odd, 3..2^W-5.
REQ-006 SHALL have a, b  input  W each  curve coefficients of y^2 = x^3 + a*x + b mod p; caller guarantees a, b < p.
REQ-007 SHALL have x, y  input  W each  candidate point, normally the scalar-multiplier outx/outy.
REQ-008 SHALL have Busy  output  1  high while a check is in progress.
REQ-009 SHALL have Done  output  1  one-cycle pulse when the result is valid.
REQ-010 SHALL have On_curve  output  1  result: point satisfies the curve equation.
REQ-011 SHALL have Range_err  output  1  result: x >= p or y >= p.
REQ-012 SHALL have Lhs, Rhs  output  W each  computed y^2 mod p and x^3+a*x+b mod p.

Function
REQ-013 SHALL implement states IDLE, CHK, MUL_YY, MUL_XX, MUL_XXX, MUL_AX, SUM, DONE.
REQ-014 In IDLE with Start=1, SHALL latch p, a, b, x, y into internal registers at that edge, clear On_curve and Range_err, and go to CHK; later input changes SHALL have no effect.
REQ-015 CHK (1 cycle): if x>=p or y>=p, SHALL set Range_err=1 and On_curve=0 and go to DONE; otherwise go to MUL_YY.
REQ-016 Each MUL state SHALL last exactly W cycles and perform MSB-first interleaved modular multiplication, one multiplier bit per cycle: acc = (2*acc mod p), then acc = (acc + multiplicand) mod p if the bit is 1; acc starts at 0.
REQ-017 Intermediate sums SHALL use W+1 bits; reduction SHALL be a single conditional subtract of p.
REQ-018 MUL_YY SHALL compute y*y into Lhs; MUL_XX x*x into t; MUL_XXX t*x into t; MUL_AX a*x into u.
REQ-019 SUM (1 cycle) SHALL compute Rhs = ((t+u) mod p + b) mod p, and On_curve = (Lhs == new Rhs).
REQ-020 DONE (1 cycle) SHALL assert Done=1, then go to IDLE.
REQ-021 Latency for in-range points SHALL be fixed: with Start sampled at edge 0, Done SHALL be high during cycle 4*W+3 (35 for W=8); for range error, during cycle 2.
REQ-022 Busy SHALL be high in CHK through SUM and low in IDLE and DONE.
REQ-023 Start outside IDLE, including in DONE, SHALL be ignored, with no queuing.
REQ-024 Lhs, Rhs, On_curve and Range_err SHALL hold their values from DONE until the next accepted Start.
REQ-025 On range error, Lhs and Rhs SHALL be 0.
REQ-026 Back-to-back: Start asserted in the cycle immediately after Done SHALL be accepted.

Reset
REQ-027 Reset=1 at an edge SHALL force IDLE and set Busy=0, Done=0, On_curve=0, Range_err=0, Lhs=0, Rhs=0, acc=t=u=0, and the bit counter to 0.
REQ-028 Reset SHALL take priority over Start and abort any check in progress, with no Done pulse for the aborted check.

Verification
REQ-029 p=17, a=2, b=2, x=5, y=1, Start -> Done at cycle 35; Lhs=1, Rhs=1, On_curve=1, Range_err=0.
REQ-030 Same curve, x=5, y=2 -> Lhs=4, Rhs=1, On_curve=0; then x=6, y=3 issued the cycle after Done -> Lhs=9, Rhs=9, On_curve=1.
REQ-031 p=17, x=17, y=1 -> Done at cycle 2, Range_err=1, On_curve=0, Lhs=Rhs=0.
REQ-032 p=251, a=b=x=y=250 -> Lhs=1, Rhs=250, On_curve=0; checks the W+1-bit carry path.
REQ-033 Start again at cycle 10 of a check -> ignored; result and Done timing unchanged.
REQ-034 Reset at cycle 20 of a check -> outputs zero, IDLE next cycle, no Done; a new Start then runs a full 35-cycle check correctly.

Source files
------------

// File: rtl/curve_point_check.sv
// Checks whether (x, y) lies on y^2 = x^3 + a*x + b mod p, using one
// bit-serial MSB-first modular multiplier shared across four products.
// Ports: Clk, Reset (sync, active-high), Start, p/a/b/x/y operands in;
// Busy, Done (1-cycle pulse), On_curve, Range_err, Lhs, Rhs results out.
module curve_point_check #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [W-1:0] p,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         Busy,
    output logic         Done,
    output logic         On_curve,
    output logic         Range_err,
    output logic [W-1:0] Lhs,
    output logic [W-1:0] Rhs
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHK, S_MUL_YY, S_MUL_XX,
        S_MUL_XXX, S_MUL_AX, S_SUM, S_DONE
    } state_t;

    // Operands are < m, so the W+1-bit sum needs at most one subtract.
    function automatic logic [W-1:0] mod_add(
        input logic [W-1:0] l,
        input logic [W-1:0] r,
        input logic [W-1:0] m
    );
        logic [W:0] s;
        s = {1'b0, l} + {1'b0, r};
        if (s >= {1'b0, m})
            s = s - {1'b0, m};
        return s[W-1:0];
    endfunction

    state_t         state_q, state_d;
    logic [W-1:0]   p_q, p_d, a_q, a_d, b_q, b_d;
    logic [W-1:0]   x_q, x_d, y_q, y_d;
    logic [W-1:0]   acc_q, acc_d, t_q, t_d, u_q, u_d;
    logic [W-1:0]   mq_q, mq_d;
    logic [W-1:0]   lhs_q, lhs_d, rhs_q, rhs_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           on_q, on_d, rg_q, rg_d;

    logic [W-1:0]   mcand, dbl, step, tu, sum;
    logic           last;

    always_comb begin
        unique case (state_q)
            S_MUL_YY:  mcand = y_q;
            S_MUL_XX:  mcand = x_q;
            S_MUL_XXX: mcand = t_q;
            S_MUL_AX:  mcand = a_q;
            default:   mcand = '0;
        endcase
    end

    // One interleaved step; mq_q holds the remaining multiplier bits, MSB first.
    assign dbl  = mod_add(acc_q, acc_q, p_q);
    assign step = mq_q[W-1] ? mod_add(dbl, mcand, p_q) : dbl;
    assign last = (cnt_q == CW'(W-1));
    assign tu   = mod_add(t_q, u_q, p_q);
    assign sum  = mod_add(tu, b_q, p_q);

    always_comb begin
        state_d = state_q;
        p_d = p_q; a_d = a_q; b_d = b_q; x_d = x_q; y_d = y_q;
        acc_d = acc_q; t_d = t_q; u_d = u_q; mq_d = mq_q;
        lhs_d = lhs_q; rhs_d = rhs_q; cnt_d = cnt_q;
        on_d = on_q; rg_d = rg_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    p_d = p; a_d = a; b_d = b; x_d = x; y_d = y;
                    on_d = 1'b0; rg_d = 1'b0;
                    lhs_d = '0; rhs_d = '0;
                    acc_d = '0; cnt_d = '0;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (x_q >= p_q || y_q >= p_q) begin
                    rg_d = 1'b1;
                    on_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    mq_d = y_q;
                    acc_d = '0;
                    cnt_d = '0;
                    state_d = S_MUL_YY;
                end
            end
            S_MUL_YY, S_MUL_XX, S_MUL_XXX, S_MUL_AX: begin
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                mq_d = mq_q << 1;
                if (last) begin
                    acc_d = '0;
                    cnt_d = '0;
                    // Every remaining product uses x as the multiplier.
                    mq_d = x_q;
                    unique case (state_q)
                        S_MUL_YY: begin
                            lhs_d = step;
                            state_d = S_MUL_XX;
                        end
                        S_MUL_XX: begin
                            t_d = step;
                            state_d = S_MUL_XXX;
                        end
                        S_MUL_XXX: begin
                            t_d = step;
                            state_d = S_MUL_AX;
                        end
                        default: begin
                            u_d = step;
                            state_d = S_SUM;
                        end
                    endcase
                end
            end
            S_SUM: begin
                rhs_d = sum;
                on_d = (lhs_q == sum);
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            p_q <= '0; a_q <= '0; b_q <= '0; x_q <= '0; y_q <= '0;
            acc_q <= '0; t_q <= '0; u_q <= '0; mq_q <= '0;
            lhs_q <= '0; rhs_q <= '0; cnt_q <= '0;
            on_q <= 1'b0; rg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q <= p_d; a_q <= a_d; b_q <= b_d; x_q <= x_d; y_q <= y_d;
            acc_q <= acc_d; t_q <= t_d; u_q <= u_d; mq_q <= mq_d;
            lhs_q <= lhs_d; rhs_q <= rhs_d; cnt_q <= cnt_d;
            on_q <= on_d; rg_q <= rg_d;
        end
    end

    assign Busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign Done      = (state_q == S_DONE);
    assign On_curve  = on_q;
    assign Range_err = rg_q;
    assign Lhs       = lhs_q;
    assign Rhs       = rhs_q;

endmodule
